// File: rtl/id_fetch_arbiter.sv
// id_fetch_arbiter: shares the ID-stage fetch-entry register between the
// frontend fetch queue and an instruction-injection port. Injection wins by
// default and may hold the port for a whole sequence; a saturating
// starvation counter forces fetch through when it has waited too long.

package config_pkg;
    typedef struct packed {
        int unsigned FetchEntryW;  // 0 = use ariane_pkg::fetch_entry_t as-is
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{FetchEntryW: 0};
endpackage

package ariane_pkg;
    typedef struct packed {
        logic [63:0] address;
        logic [31:0] instruction;
        logic        ex_valid;
        logic        bp_taken;
    } fetch_entry_t;
endpackage

module id_fetch_arbiter #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned           MaxWait = 8
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      flush_i,
    input  logic [$bits(ariane_pkg::fetch_entry_t)-1:0] fetch_entry_i,
    input  logic                                      fetch_valid_i,
    output logic                                      fetch_ready_o,
    input  logic [$bits(ariane_pkg::fetch_entry_t)-1:0] inj_entry_i,
    input  logic                                      inj_valid_i,
    input  logic                                      inj_last_i,
    output logic                                      inj_ready_o,
    output logic [$bits(ariane_pkg::fetch_entry_t)-1:0] out_entry_o,
    output logic                                      out_valid_o,
    input  logic                                      out_ready_i,
    output logic                                      out_src_o,
    output logic                                      lock_o
);

    localparam int unsigned EntryW = $bits(ariane_pkg::fetch_entry_t);
    localparam int unsigned CntW   = (MaxWait > 0) ? $clog2(MaxWait + 1) : 1;
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxWait);

    localparam logic [0:0] StFree   = 1'b0;
    localparam logic [0:0] StLocked = 1'b1;

    localparam logic SrcFetch = 1'b0;
    localparam logic SrcInj   = 1'b1;

    // Elaboration-time guards on the configuration.
    if (MaxWait > 255) begin : g_bad_maxwait
        $error("id_fetch_arbiter: MaxWait must be in 0..255");
    end
    if (CVA6Cfg.FetchEntryW != 0 && CVA6Cfg.FetchEntryW != EntryW) begin : g_bad_cfg
        $error("id_fetch_arbiter: CVA6Cfg fetch entry width disagrees with fetch_entry_t");
    end

    logic [0:0]      state_d, state_q;
    logic [CntW-1:0] starve_d, starve_q;

    logic force_fetch;
    logic grant;
    logic xfer;
    logic fetch_xfer;
    logic inj_xfer;

    // Grant selection and output/ready muxing; valid never depends on out_ready_i.
    always_comb begin
        force_fetch = (MaxWait != 0) && (starve_q == MaxCnt) && (state_q == StFree);

        grant = SrcFetch;
        if (state_q == StLocked) begin
            grant = SrcInj;
        end else if (force_fetch && fetch_valid_i) begin
            grant = SrcFetch;
        end else if (inj_valid_i) begin
            grant = SrcInj;
        end

        out_src_o     = grant;
        out_entry_o   = (grant == SrcInj) ? inj_entry_i : fetch_entry_i;
        out_valid_o   = ((grant == SrcInj) ? inj_valid_i : fetch_valid_i) && !flush_i;
        fetch_ready_o = (grant == SrcFetch) && fetch_valid_i && out_ready_i && !flush_i;
        inj_ready_o   = (grant == SrcInj) && inj_valid_i && out_ready_i && !flush_i;
        lock_o        = (state_q == StLocked);

        xfer       = out_valid_o && out_ready_i;
        fetch_xfer = xfer && (grant == SrcFetch);
        inj_xfer   = xfer && (grant == SrcInj);
    end

    // Next-state for lock FSM and starvation counter; flush overrides everything.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;

        if (flush_i) begin
            state_d  = StFree;
            starve_d = '0;
        end else begin
            // Any injection transfer ends the lock if it is the last entry and
            // starts/continues it otherwise, regardless of the current state.
            if (inj_xfer) begin
                state_d = inj_last_i ? StFree : StLocked;
            end

            if (fetch_xfer || !fetch_valid_i) begin
                starve_d = '0;
            end else if (starve_q != MaxCnt) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StFree;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_id_fetch_arbiter.sv
// tb_id_fetch_arbiter: directed-vector bench for id_fetch_arbiter. Two
// instances share all inputs: dut (MaxWait = 8) and dut0 (MaxWait = 0).

module tb_id_fetch_arbiter;

    localparam int unsigned EntryW = $bits(ariane_pkg::fetch_entry_t);

    logic              clk;
    logic              rst_ni;
    logic              flush_i;
    logic [EntryW-1:0] fetch_entry_i;
    logic              fetch_valid_i;
    logic [EntryW-1:0] inj_entry_i;
    logic              inj_valid_i;
    logic              inj_last_i;
    logic              out_ready_i;

    logic              fetch_ready_o,  inj_ready_o,  out_valid_o,  out_src_o,  lock_o;
    logic [EntryW-1:0] out_entry_o;
    logic              fetch_ready_o0, inj_ready_o0, out_valid_o0, out_src_o0, lock_o0;
    logic [EntryW-1:0] out_entry_o0;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [EntryW-1:0] fe;
    logic [EntryW-1:0] ie;

    id_fetch_arbiter #(.MaxWait(8)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .fetch_entry_i (fetch_entry_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_ready_o (fetch_ready_o),
        .inj_entry_i   (inj_entry_i),
        .inj_valid_i   (inj_valid_i),
        .inj_last_i    (inj_last_i),
        .inj_ready_o   (inj_ready_o),
        .out_entry_o   (out_entry_o),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_src_o     (out_src_o),
        .lock_o        (lock_o)
    );

    id_fetch_arbiter #(.MaxWait(0)) dut0 (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .fetch_entry_i (fetch_entry_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_ready_o (fetch_ready_o0),
        .inj_entry_i   (inj_entry_i),
        .inj_valid_i   (inj_valid_i),
        .inj_last_i    (inj_last_i),
        .inj_ready_o   (inj_ready_o0),
        .out_entry_o   (out_entry_o0),
        .out_valid_o   (out_valid_o0),
        .out_ready_i   (out_ready_i),
        .out_src_o     (out_src_o0),
        .lock_o        (lock_o0)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic fv, input logic iv, input logic il, input logic rdy);
        fetch_valid_i = fv;
        inj_valid_i   = iv;
        inj_last_i    = il;
        out_ready_i   = rdy;
    endtask

    // Idle cycle: both sources invalid, clears the starvation counter.
    task automatic idle();
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        flush_i = 1'b0;
        tick();
    endtask

    initial begin
        fe = EntryW'(128'h0000_0000_F00D_0000_0000_1000_0000_0013);
        ie = EntryW'(128'h0000_0000_1A1A_0000_0000_8000_0010_0073);
        fetch_entry_i = fe;
        inj_entry_i   = ie;
        rst_ni  = 1'b0;
        flush_i = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset values with inputs at 0.
        #2;
        check_eq("rst_fetch_ready", fetch_ready_o, 0);
        check_eq("rst_inj_ready",   inj_ready_o,   0);
        check_eq("rst_out_valid",   out_valid_o,   0);
        check_eq("rst_out_src",     out_src_o,     0);
        check_eq("rst_lock",        lock_o,        0);
        check_eq("rst_out_entry",   out_entry_o,   fe);
        check_eq("rst_starve",      dut.starve_q,  0);
        tick();
        rst_ni = 1'b1;
        tick();

        // Starvation forcing: both valid, single-entry injections.
        set_in(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i <= 9; i++) begin
            #2;
            check_eq($sformatf("starve_src_%0d", i),   out_src_o,     (i == 8) ? 0 : 1);
            check_eq($sformatf("starve_fr_%0d", i),    fetch_ready_o, (i == 8) ? 1 : 0);
            check_eq($sformatf("starve_ir_%0d", i),    inj_ready_o,   (i == 8) ? 0 : 1);
            check_eq($sformatf("starve_entry_%0d", i), out_entry_o,   (i == 8) ? fe : ie);
            check_eq($sformatf("starve_cnt_%0d", i),   dut.starve_q,  (i == 9) ? 0 : i);
            check_eq($sformatf("starve_lock_%0d", i),  lock_o,        0);
            tick();
        end

        // Four-entry locked injection with fetch continuously valid.
        idle();
        for (int k = 1; k <= 4; k++) begin
            set_in(1'b1, 1'b1, (k == 4), 1'b1);
            #2;
            check_eq($sformatf("lock_src_%0d", k), out_src_o,     1);
            check_eq($sformatf("lock_fr_%0d", k),  fetch_ready_o, 0);
            check_eq($sformatf("lock_ir_%0d", k),  inj_ready_o,   1);
            tick();
            check_eq($sformatf("lock_state_%0d", k), lock_o, (k < 4) ? 1 : 0);
        end
        set_in(1'b1, 1'b0, 1'b0, 1'b1);
        #2;
        check_eq("lock_after_src", out_src_o,     0);
        check_eq("lock_after_fr",  fetch_ready_o, 1);
        tick();

        // Flush while locked after 2 of 4 entries, flush coinciding with inj_last_i.
        idle();
        set_in(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        tick();
        check_eq("flush_pre_lock", lock_o, 1);
        flush_i    = 1'b1;
        inj_last_i = 1'b1;
        #2;
        check_eq("flush_out_valid", out_valid_o,   0);
        check_eq("flush_lock",      lock_o,        1);
        check_eq("flush_fr",        fetch_ready_o, 0);
        check_eq("flush_ir",        inj_ready_o,   0);
        tick();
        flush_i = 1'b0;
        set_in(1'b1, 1'b0, 1'b0, 1'b1);
        #2;
        check_eq("flush_next_lock",   lock_o,        0);
        check_eq("flush_next_starve", dut.starve_q,  0);
        check_eq("flush_next_src",    out_src_o,     0);
        check_eq("flush_next_fr",     fetch_ready_o, 1);
        tick();

        // Backpressure: out_ready_i low for 20 cycles with both valid.
        idle();
        set_in(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            #2;
            check_eq($sformatf("bp_src_%0d", i),   out_src_o,     (i >= 8) ? 0 : 1);
            check_eq($sformatf("bp_fr_%0d", i),    fetch_ready_o, 0);
            check_eq($sformatf("bp_ir_%0d", i),    inj_ready_o,   0);
            check_eq($sformatf("bp_valid_%0d", i), out_valid_o,   1);
            check_eq($sformatf("bp_cnt_%0d", i),   dut.starve_q,  (i >= 8) ? 8 : i);
            check_eq($sformatf("bp_src0_%0d", i),  out_src_o0,    1);
            tick();
        end
        out_ready_i = 1'b1;
        #2;
        check_eq("bp_release_src", out_src_o,     0);
        check_eq("bp_release_fr",  fetch_ready_o, 1);
        check_eq("bp_release_ir",  inj_ready_o,   0);
        tick();
        #2;
        check_eq("bp_release_cnt", dut.starve_q, 0);

        // MaxWait = 0: fetch never granted over 50 cycles of contention.
        idle();
        set_in(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 50; i++) begin
            #2;
            check_eq($sformatf("mw0_src_%0d", i), out_src_o0,     1);
            check_eq($sformatf("mw0_fr_%0d", i),  fetch_ready_o0, 0);
            tick();
        end

        // Locked past saturation, then asynchronous reset mid-sequence.
        idle();
        set_in(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        check_eq("rlock_lock", lock_o, 1);
        out_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #2;
            check_eq($sformatf("rlock_src_%0d", i), out_src_o,     1);
            check_eq($sformatf("rlock_fr_%0d", i),  fetch_ready_o, 0);
            tick();
        end
        #2;
        check_eq("rlock_sat_cnt", dut.starve_q, 8);
        rst_ni = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("arst_lock",      lock_o,       0);
        check_eq("arst_out_valid", out_valid_o,  0);
        check_eq("arst_starve",    dut.starve_q, 0);
        tick();
        rst_ni = 1'b1;
        tick();
        set_in(1'b1, 1'b1, 1'b1, 1'b1);
        #2;
        check_eq("arst_after_lock", lock_o,    0);
        check_eq("arst_after_src",  out_src_o, 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
